sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/sprite_blitter.sv | 163 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: tile-aligned sprite erase/redraw engine driving a VGA plot port.
// Optional build macro SPRITE_TRANSPARENT_EN suppresses plots of cleared bitmap pixels.
module sprite_blitter #(
    parameter int SPRITE_W = 5,
    parameter int SPRITE_H = 5,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COL_W    = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         go,
    input  logic [7:0]                   tile_x,
    input  logic [6:0]                   tile_y,
    input  logic [SPRITE_W*SPRITE_H-1:0] shape,
    input  logic [COL_W-1:0]             colour,
    input  logic [COL_W-1:0]             bg_colour,
    output logic                         plot,
    output logic [7:0]                   x_out,
    output logic [6:0]                   y_out,
    output logic [COL_W-1:0]             col_out,
    output logic                         busy,
    output logic                         done
);

    localparam int         NPIX   = SPRITE_W * SPRITE_H;
    localparam logic [2:0] C_LAST = 3'(SPRITE_W - 1);
    localparam logic [2:0] R_LAST = 3'(SPRITE_H - 1);
    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ERASE,
        DRAW,
        DONE
    } state_t;

    state_t state, state_d;

    logic [7:0]       org_x, prev_x;
    logic [6:0]       org_y, prev_y;
    logic             prev_valid;
    logic [NPIX-1:0]  shape_q;
    logic [COL_W-1:0] colour_q, bg_q;
    logic [2:0]       cnt_c, cnt_r;

    logic [15:0]      prod_x, prod_y;
    logic             last_px;
    logic [7:0]       base_x, px;
    logic [6:0]       base_y, py;
    logic             on_screen;
    logic             shape_bit;

    assign prod_x  = 16'(tile_x) * 16'(SPRITE_W);
    assign prod_y  = 16'(tile_y) * 16'(SPRITE_H);
    assign last_px = (cnt_c == C_LAST) && (cnt_r == R_LAST);

    // Shape is shifted MSB-first during DRAW, matching raster order.
    assign shape_bit = shape_q[NPIX-1];

    assign base_x    = (state == ERASE) ? prev_x : org_x;
    assign base_y    = (state == ERASE) ? prev_y : org_y;
    assign px        = base_x + {5'd0, cnt_c};
    assign py        = base_y + {4'd0, cnt_r};
    assign on_screen = ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (go) state_d = LOAD;
            LOAD:    state_d = prev_valid ? ERASE : DRAW;
            ERASE:   if (last_px) state_d = DRAW;
            DRAW:    if (last_px) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        plot    = 1'b0;
        x_out   = '0;
        y_out   = '0;
        col_out = '0;
        busy    = (state != IDLE);
        done    = (state == DONE);
        unique case (state)
            ERASE: begin
                x_out   = px;
                y_out   = py;
                col_out = bg_q;
                plot    = on_screen;
            end
            DRAW: begin
                x_out   = px;
                y_out   = py;
                col_out = shape_bit ? colour_q : bg_q;
`ifdef SPRITE_TRANSPARENT_EN
                plot    = on_screen && shape_bit;
`else
                plot    = on_screen;
`endif
            end
            default: begin
                plot = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt_c      <= '0;
            cnt_r      <= '0;
            org_x      <= '0;
            org_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            shape_q    <= '0;
            colour_q   <= '0;
            bg_q       <= '0;
        end else begin
            state <= state_d;

            if (state == LOAD) begin
                org_x    <= prod_x[7:0];
                org_y    <= prod_y[6:0];
                shape_q  <= shape;
                colour_q <= colour;
                bg_q     <= bg_colour;
            end

            if (state == DRAW) begin
                shape_q <= shape_q << 1;
            end

            if (state == ERASE || state == DRAW) begin
                if (last_px) begin
                    cnt_c <= '0;
                    cnt_r <= '0;
                end else if (cnt_c == C_LAST) begin
                    cnt_c <= '0;
                    cnt_r <= cnt_r + 3'd1;
                end else begin
                    cnt_c <= cnt_c + 3'd1;
                end
            end else begin
                cnt_c <= '0;
                cnt_r <= '0;
            end

            // Only a completed draw becomes the sprite to erase next time.
            if (state == DRAW && state_d == DONE) begin
                prev_x     <= org_x;
                prev_y     <= org_y;
                prev_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and randomized checks of sprite_blitter
// against a cycle-list reference model of the drawing sequence.
module tb_sprite_blitter;

    localparam int W    = 5;
    localparam int H    = 5;
    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int CW   = 3;
    localparam int NPIX = W * H;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            go = 1'b0;
    logic [7:0]      tile_x = '0;
    logic [6:0]      tile_y = '0;
    logic [NPIX-1:0] shape = '0;
    logic [CW-1:0]   colour = '0;
    logic [CW-1:0]   bg_colour = '0;
    logic            plot;
    logic [7:0]      x_out;
    logic [6:0]      y_out;
    logic [CW-1:0]   col_out;
    logic            busy;
    logic            done;

    int vectors = 0;
    int errors  = 0;

    sprite_blitter #(
        .SPRITE_W(W),
        .SPRITE_H(H),
        .SCREEN_W(SW),
        .SCREEN_H(SH),
        .COL_W(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .go(go),
        .tile_x(tile_x),
        .tile_y(tile_y),
        .shape(shape),
        .colour(colour),
        .bg_colour(bg_colour),
        .plot(plot),
        .x_out(x_out),
        .y_out(y_out),
        .col_out(col_out),
        .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one expected output record per future cycle.
    typedef struct {
        logic          busy;
        logic          done;
        logic          plot;
        logic [7:0]    x;
        logic [6:0]    y;
        logic [CW-1:0] col;
        logic          upd;
        logic [7:0]    nx;
        logic [6:0]    ny;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t idle_e;
    logic       pend = 1'b0;
    logic       chk_en = 1'b0;
    logic       m_pv = 1'b0;
    logic [7:0] m_px = '0;
    logic [6:0] m_py = '0;

    function automatic exp_t pixel(input int x, input int y,
                                   input logic [CW-1:0] c, input logic vis);
        exp_t e;
        e      = '{default: '0};
        e.busy = 1'b1;
        e.x    = 8'(x);
        e.y    = 7'(y);
        e.col  = c;
        e.plot = vis && (int'(e.x) < SW) && (int'(e.y) < SH);
        return e;
    endfunction

    task automatic gen_op();
        exp_t e;
        logic [7:0] ox;
        logic [6:0] oy;
        logic b;
        ox = 8'(int'(tile_x) * W);
        oy = 7'(int'(tile_y) * H);
        if (m_pv) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    q.push_back(pixel(int'(m_px) + c, int'(m_py) + r, bg_colour, 1'b1));
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                b = shape[NPIX-1-(r*W+c)];
`ifdef SPRITE_TRANSPARENT_EN
                q.push_back(pixel(int'(ox) + c, int'(oy) + r, b ? colour : bg_colour, b));
`else
                q.push_back(pixel(int'(ox) + c, int'(oy) + r, b ? colour : bg_colour, 1'b1));
`endif
            end
        end
        e      = '{default: '0};
        e.busy = 1'b1;
        e.done = 1'b1;
        e.upd  = 1'b1;
        e.nx   = ox;
        e.ny   = oy;
        q.push_back(e);
    endtask

    initial begin
        idle_e = '{default: '0};
        cur    = idle_e;
    end

    always @(posedge clock) begin
        exp_t e;
        if (reset) begin
            q.delete();
            pend   = 1'b0;
            m_pv   = 1'b0;
            m_px   = '0;
            m_py   = '0;
            cur    = idle_e;
            chk_en = 1'b1;
        end else begin
            if (pend) begin
                gen_op();
                pend = 1'b0;
            end else if (q.size() == 0 && !cur.busy && go) begin
                e      = '{default: '0};
                e.busy = 1'b1;
                q.push_back(e);
                pend = 1'b1;
            end
            if (q.size() > 0) begin
                cur = q.pop_front();
                if (cur.upd) begin
                    m_pv = 1'b1;
                    m_px = cur.nx;
                    m_py = cur.ny;
                end
            end else begin
                cur = idle_e;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en)
            check("cycle {busy,done,plot,x,y,col}",
                  32'({busy, done, plot, x_out, y_out, col_out}),
                  32'({cur.busy, cur.done, cur.plot, cur.x, cur.y, cur.col}));
    end

    task automatic set_in(input int tx, input int ty, input logic [NPIX-1:0] shp,
                          input int c, input int bg);
        tile_x    = 8'(tx);
        tile_y    = 7'(ty);
        shape     = shp;
        colour    = CW'(c);
        bg_colour = CW'(bg);
    endtask

    // One request; tallies observed cycles to done, plots, plots below x_split,
    // and plots carrying the foreground colour.
    task automatic run_op(input int x_split, output int cyc, output int nplot,
                          output int nlow, output int ncol);
        cyc = 0; nplot = 0; nlow = 0; ncol = 0;
        go = 1'b1;
        while (cyc < 300) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            go = 1'b0;
            if (plot) begin
                nplot++;
                if (int'(x_out) < x_split) nlow++;
                if (col_out == colour) ncol++;
            end
            if (done) break;
        end
    endtask

    int cyc, nplot, nlow, ncol, ndone;
    logic [NPIX-1:0] ones;
    logic [NPIX-1:0] top;

    initial begin
        ones = '1;
        top  = '0;
        top[NPIX-1] = 1'b1;

        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset outputs", 32'({busy, done, plot, x_out, y_out, col_out}), 32'd0);

        set_in(2, 3, ones, 6, 1);
        run_op(10, cyc, nplot, nlow, ncol);
        check("first op cycles", 32'(cyc), 32'd27);
        check("first op plots", 32'(nplot), 32'd25);
        check("first op erase plots", 32'(nlow), 32'd0);
        check("first op colour plots", 32'(ncol), 32'd25);

        @(negedge clock);
        set_in(3, 3, ones, 6, 1);
        run_op(15, cyc, nplot, nlow, ncol);
        check("second op cycles", 32'(cyc), 32'd52);
        check("second op plots", 32'(nplot), 32'd50);
        check("second op erase plots", 32'(nlow), 32'd25);
        check("second op colour plots", 32'(ncol), 32'd25);

        @(negedge clock);
        set_in(0, 0, top, 5, 0);
        run_op(0, cyc, nplot, nlow, ncol);
        check("single bit cycles", 32'(cyc), 32'd52);
        check("single bit colour plots", 32'(ncol), 32'd1);
`ifdef SPRITE_TRANSPARENT_EN
        check("single bit plots", 32'(nplot), 32'd26);
`else
        check("single bit plots", 32'(nplot), 32'd50);
`endif

        @(negedge clock);
        set_in(31, 23, ones, 3, 2);
        run_op(155, cyc, nplot, nlow, ncol);
        check("corner cycles", 32'(cyc), 32'd52);
        check("corner plots", 32'(nplot), 32'd50);
        check("corner erase plots", 32'(nlow), 32'd25);

        // Reset at the 10th DRAW cycle of an op that erases first.
        @(negedge clock);
        set_in(4, 4, ones, 7, 0);
        go  = 1'b1;
        cyc = 0;
        while (cyc < 36) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            go = 1'b0;
        end
        check("mid draw busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("after reset outputs",
              32'({busy, done, plot, x_out, y_out, col_out}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        set_in(5, 5, ones, 4, 1);
        run_op(0, cyc, nplot, nlow, ncol);
        check("post reset cycles", 32'(cyc), 32'd27);

        // go held high: requests accepted only from IDLE.
        @(negedge clock);
        go    = 1'b1;
        ndone = 0;
        for (int i = 0; i < 159; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        go = 1'b0;
        check("held go dones", 32'(ndone), 32'd3);
        for (int i = 0; i < 100 && busy; i++) @(negedge clock);
        check("held go drained", 32'(busy), 32'd0);

        // Randomized traffic; inputs may change on any cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            set_in($urandom_range(0, 40), $urandom_range(0, 24),
                   NPIX'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
            go    = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 499) == 0);
        end
        @(negedge clock);
        go    = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
